// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encodings and default parameters for capture_control
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLUSH     = 2'd1,
        WAIT_LOCK = 2'd2,
        RUN       = 2'd3
    } cap_state_e;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FLUSH     = 2'd1;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam int DEF_NUM_CH       = 24;
    localparam int DEF_LOCK_TIMEOUT = 4095;
    localparam int DEF_FLUSH_CYCLES = 4;
    localparam int DEF_MAX_ERRORS   = 3;

endpackage

// File: rtl/capture_control_if.sv
// rtl/capture_control_if.sv - controller <-> capture channel bundle
interface capture_control_if #(
    parameter int NUM_CH = capture_pkg::DEF_NUM_CH
) ();
    logic [NUM_CH-1:0] cap_locked;
    logic [NUM_CH-1:0] cap_ready;
    logic [NUM_CH-1:0] cap_q;
    logic [NUM_CH-1:0] cap_invalid;
    logic              cap_rst;
    logic [NUM_CH-1:0] cap_ack;

    modport master (
        input  cap_locked, cap_ready, cap_q, cap_invalid,
        output cap_rst, cap_ack
    );

    modport slave (
        output cap_locked, cap_ready, cap_q, cap_invalid,
        input  cap_rst, cap_ack
    );
endinterface

// File: rtl/capture_assembler.sv
// rtl/capture_assembler.sv - per-channel sample word assembly with overrun and optional skew check (CAPTURE_CTRL_SKEW_EN)
module capture_assembler #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              en,
    input  logic [NUM_CH-1:0] cap_ready,
    input  logic [NUM_CH-1:0] cap_q,
    output logic [NUM_CH-1:0] data,
    output logic              valid,
    output logic              overrun,
    output logic              skew_err
);
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] word;
    logic [NUM_CH-1:0] word_nxt;
    logic              strobe;
    logic              complete;

    assign strobe   = ce && en;
    // A repeat strobe wins over completion even if it also fills the last gap.
    assign overrun  = strobe && (|(cap_ready & pending));
    assign complete = strobe && !overrun && (&(pending | cap_ready));
    assign word_nxt = (word & ~cap_ready) | (cap_q & cap_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            word    <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= complete;
            if (!en || overrun || complete) begin
                pending <= '0;
            end else if (strobe) begin
                pending <= pending | cap_ready;
            end
            if (strobe) begin
                word <= word_nxt;
            end
            if (complete) begin
                data <= word_nxt;
            end
        end
    end

`ifdef CAPTURE_CTRL_SKEW_EN
    logic [3:0] skew_q;

    always_ff @(posedge clk) begin
        if (rst || !en || overrun || complete) begin
            skew_q <= 4'd0;
        end else if (strobe && (|pending) && skew_q != 4'hF) begin
            skew_q <= skew_q + 4'd1;
        end
    end

    // skew_q lags the current ce-cycle by one, so >=2 means the spread exceeds 2.
    assign skew_err = strobe && (|pending) && (skew_q >= 4'd2);
`else
    assign skew_err = 1'b0;
`endif

endmodule

// File: rtl/capture_control.sv
// rtl/capture_control.sv - capture channel sequencer and word assembler top (optional CAPTURE_CTRL_SKEW_EN)
module capture_control
    import capture_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MAX_ERRORS   = DEF_MAX_ERRORS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              enable,
    capture_control_if.master cap,
    output logic [NUM_CH-1:0] data,
    output logic              valid,
    output logic [1:0]        state,
    output logic [7:0]        resyncs
);
    localparam int TMR_MAX = (LOCK_TIMEOUT > FLUSH_CYCLES) ? LOCK_TIMEOUT : FLUSH_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int ERR_RAW = $clog2(MAX_ERRORS + 1);
    localparam int ERR_W   = (ERR_RAW < 1) ? 1 : ERR_RAW;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [ERR_W-1:0]  err_q;
    logic [NUM_CH-1:0] inv_prev;
    logic              all_locked;
    logic              inv_rise;
    logic              asm_en;
    logic              ovr;
    logic              skew_err;
    logic              resync;

    assign all_locked  = &cap.cap_locked;
    assign inv_rise    = |(cap.cap_invalid & ~inv_prev);
    assign asm_en      = (state_q == ST_RUN) && enable;
    assign cap.cap_rst = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign state       = state_q;
    assign resync      = (state_d == ST_FLUSH) &&
                         ((state_q == ST_WAIT_LOCK) || (state_q == ST_RUN));

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (ce) begin
            case (state_q)
                ST_IDLE: state_d = ST_FLUSH;
                ST_FLUSH: begin
                    if (tmr_q == TMR_W'(FLUSH_CYCLES - 1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (all_locked) state_d = ST_RUN;
                    else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) state_d = ST_FLUSH;
                end
                default: begin
                    if (!all_locked || err_q == ERR_W'(MAX_ERRORS) || ovr || skew_err)
                        state_d = ST_FLUSH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            err_q       <= '0;
            inv_prev    <= '0;
            cap.cap_ack <= '0;
            resyncs     <= 8'd0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q || !enable) begin
                tmr_q <= '0;
            end else if (ce && (state_q == ST_FLUSH || state_q == ST_WAIT_LOCK)) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end

            if (ce) begin
                inv_prev <= cap.cap_invalid;
            end

            // Error budget is per RUN visit; anything outside RUN starts it over.
            if (state_q != ST_RUN) begin
                err_q <= '0;
            end else if (ce && inv_rise && err_q != ERR_W'(MAX_ERRORS)) begin
                err_q <= err_q + ERR_W'(1);
            end

            // Keyed to the next state so the ack is never seen outside RUN.
            cap.cap_ack <= (state_d == ST_RUN) ? cap.cap_invalid : '0;

            if (resync && resyncs != 8'hFF) begin
                resyncs <= resyncs + 8'd1;
            end
        end
    end

    capture_assembler #(
        .NUM_CH (NUM_CH)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .en        (asm_en),
        .cap_ready (cap.cap_ready),
        .cap_q     (cap.cap_q),
        .data      (data),
        .valid     (valid),
        .overrun   (ovr),
        .skew_err  (skew_err)
    );

endmodule

// File: tb/tb_capture_control.sv
// tb/tb_capture_control.sv - directed self-checking bench for capture_control
module tb_capture_control;
    import capture_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       enable;
    logic [3:0] data;
    logic       valid;
    logic [1:0] state;
    logic [7:0] resyncs;

    int n_cmp = 0;
    int n_bad = 0;

    capture_control_if #(.NUM_CH(4)) cif ();

    capture_control #(
        .NUM_CH       (4),
        .LOCK_TIMEOUT (16),
        .FLUSH_CYCLES (4),
        .MAX_ERRORS   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .enable  (enable),
        .cap     (cif.master),
        .data    (data),
        .valid   (valid),
        .state   (state),
        .resyncs (resyncs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ready;
        logic [3:0] q;
        logic       exp_valid;
        logic [3:0] exp_data;
    } vec_t;

    vec_t tbl [0:9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget);
        int n;
        n = 0;
        while (state != target && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", 32'(state), 32'(target));
    endtask

    task automatic count_wait(output int n);
        n = 0;
        while (state == ST_WAIT_LOCK && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ce = 1'b1;
        enable = 1'b0;
        cif.cap_locked = 4'h0;
        cif.cap_ready = 4'h0;
        cif.cap_q = 4'h0;
        cif.cap_invalid = 4'h0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_cap_rst", 32'(cif.cap_rst), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_resyncs", 32'(resyncs), 32'd0);
        check("rst_ack", 32'(cif.cap_ack), 32'd0);
        rst = 1'b0;

        // Bring-up: FLUSH for exactly 4 ce-cycles, lock arrives after 10 more.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_state", 32'(state), 32'(ST_FLUSH));
            check("flush_cap_rst", 32'(cif.cap_rst), 32'd1);
        end
        tick();
        check("wait_state_entry", 32'(state), 32'(ST_WAIT_LOCK));
        check("wait_cap_rst", 32'(cif.cap_rst), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check("still_waiting", 32'(state), 32'(ST_WAIT_LOCK));
        cif.cap_locked = 4'hF;
        tick();
        check("run_entry", 32'(state), 32'(ST_RUN));
        check("bringup_resyncs", 32'(resyncs), 32'd0);

        tbl[0] = '{4'b0001, 4'b0001, 1'b0, 4'b0000};
        tbl[1] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[2] = '{4'b0010, 4'b0000, 1'b0, 4'b0000};
        tbl[3] = '{4'b0100, 4'b0100, 1'b0, 4'b0000};
        tbl[4] = '{4'b1000, 4'b1000, 1'b1, 4'b1101};
        tbl[5] = '{4'b0000, 4'b0000, 1'b0, 4'b1101};
        tbl[6] = '{4'b1111, 4'b0110, 1'b1, 4'b0110};
        tbl[7] = '{4'b0000, 4'b1111, 1'b0, 4'b0110};
        tbl[8] = '{4'b0011, 4'b0001, 1'b0, 4'b0110};
        tbl[9] = '{4'b1100, 4'b1000, 1'b1, 4'b1001};
        for (int i = 0; i < 10; i++) begin
            cif.cap_ready = tbl[i].ready;
            cif.cap_q = tbl[i].q;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(tbl[i].exp_data));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(ST_RUN));
        end
        cif.cap_ready = 4'h0;

        // Channel 2 strobes twice before the word completes.
        cif.cap_ready = 4'b0100;
        cif.cap_q = 4'b0100;
        tick();
        tick();
        cif.cap_ready = 4'h0;
        check("ovr_valid", 32'(valid), 32'd0);
        check("ovr_state", 32'(state), 32'(ST_FLUSH));
        check("ovr_resyncs", 32'(resyncs), 32'd1);
        check("ovr_data_hold", 32'(data), 32'h9);
        tick();
        check("ovr_valid_after", 32'(valid), 32'd0);
        wait_state(ST_RUN, 20);

        // Repeat strobe on ch0 in the very cycle that would complete the word.
        cif.cap_ready = 4'b0011;
        cif.cap_q = 4'b0011;
        tick();
        cif.cap_ready = 4'b1101;
        cif.cap_q = 4'b1111;
        tick();
        cif.cap_ready = 4'h0;
        check("same_cyc_ovr_valid", 32'(valid), 32'd0);
        check("same_cyc_ovr_state", 32'(state), 32'(ST_FLUSH));
        check("same_cyc_ovr_resyncs", 32'(resyncs), 32'd2);
        tick();
        check("same_cyc_ovr_valid2", 32'(valid), 32'd0);
        wait_state(ST_RUN, 20);

        // Three separate invalid rises on ch1.
        for (int r = 0; r < 3; r++) begin
            cif.cap_invalid = 4'b0010;
            tick();
            check($sformatf("inv%0d_ack", r), 32'(cif.cap_ack), 32'h2);
            check($sformatf("inv%0d_state", r), 32'(state), 32'(ST_RUN));
            cif.cap_invalid = 4'b0000;
            tick();
            check($sformatf("inv%0d_ack_clr", r), 32'(cif.cap_ack), 32'h0);
            check($sformatf("inv%0d_state_after", r), 32'(state), (r == 2) ? 32'(ST_FLUSH) : 32'(ST_RUN));
        end
        check("inv_resyncs", 32'(resyncs), 32'd3);
        wait_state(ST_RUN, 20);

        // enable dropped with a word in progress.
        cif.cap_ready = 4'b0011;
        cif.cap_q = 4'b0011;
        tick();
        enable = 1'b0;
        cif.cap_ready = 4'b1100;
        cif.cap_q = 4'b1111;
        tick();
        cif.cap_ready = 4'h0;
        check("drop_state", 32'(state), 32'(ST_IDLE));
        check("drop_cap_rst", 32'(cif.cap_rst), 32'd1);
        check("drop_valid", 32'(valid), 32'd0);
        check("drop_data_hold", 32'(data), 32'h9);
        tick();
        check("drop_valid2", 32'(valid), 32'd0);
        check("drop_resyncs", 32'(resyncs), 32'd3);

        // Channel 3 never locks; ce stall holds FLUSH first.
        cif.cap_locked = 4'b0111;
        enable = 1'b1;
        tick();
        check("relock_flush", 32'(state), 32'(ST_FLUSH));
        ce = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("ce_stall_hold", 32'(state), 32'(ST_FLUSH));
        ce = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_state(ST_WAIT_LOCK, 20);
            count_wait(n);
            check($sformatf("timeout%0d_len", k), 32'(n), 32'd16);
            check($sformatf("timeout%0d_state", k), 32'(state), 32'(ST_FLUSH));
            check($sformatf("timeout%0d_resyncs", k), 32'(resyncs), 32'(4 + k));
        end

        // Reset in the middle of a word.
        cif.cap_locked = 4'hF;
        wait_state(ST_RUN, 40);
        cif.cap_ready = 4'b0001;
        cif.cap_q = 4'b0001;
        tick();
        rst = 1'b1;
        cif.cap_ready = 4'b1110;
        tick();
        check("midrst_state", 32'(state), 32'(ST_IDLE));
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_resyncs", 32'(resyncs), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        tick();
        cif.cap_ready = 4'h0;
        check("postrst_state", 32'(state), 32'(ST_FLUSH));
        check("postrst_valid", 32'(valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/capture_control.md
CAPTURE_CONTROL -- requirements
Module: capture_control

Interface
REQ-001 Parameter NUM_CH, default 24: number of signal-capture channels controlled.
REQ-002 Parameter LOCK_TIMEOUT, default 4095: ce-cycles allowed in WAIT_LOCK before resync.
REQ-003 Parameter FLUSH_CYCLES, default 4: ce-cycles cap_rst is held during FLUSH.
REQ-004 Parameter MAX_ERRORS, default 3: invalid events tolerated in RUN before resync.
REQ-005 clk  in  1  system clock; all logic SHALL be on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ce  in  1  supersample clock-enable, shared with all capture channels.
REQ-008 enable  in  1  level; high requests acquisition, low forces IDLE.
REQ-009 cap_locked  in  NUM_CH  per-channel lock flags.
REQ-010 cap_ready  in  NUM_CH  per-channel one-cycle sample strobes.
REQ-011 cap_q  in  NUM_CH  per-channel held sample bits.
REQ-012 cap_invalid  in  NUM_CH  per-channel invalid-edge flags.
REQ-013 cap_rst  out  1  synchronous reset to all capture channels.
REQ-014 cap_ack  out  NUM_CH  per-channel invalid acknowledge.
REQ-015 data  out  NUM_CH  assembled sample word, bit i from channel i.
REQ-016 valid  out  1  one-cycle strobe, data valid.
REQ-017 state  out  2  current FSM state encoding.
REQ-018 resyncs  out  8  saturating count of entries into FLUSH from WAIT_LOCK/RUN.

Function
REQ-019 FSM states SHALL be IDLE=0, FLUSH=1, WAIT_LOCK=2, RUN=3; state/timer advance only when ce=1, except enable low, which forces IDLE next clk.
REQ-020 IDLE -> FLUSH when enable=1; cap_rst SHALL be 1 in IDLE and FLUSH, 0 otherwise.
REQ-021 FLUSH SHALL last exactly FLUSH_CYCLES ce-cycles, clearing pending bits and error count, then -> WAIT_LOCK.
REQ-022 WAIT_LOCK -> RUN on the ce-cycle all cap_locked bits are 1; after LOCK_TIMEOUT ce-cycles without that -> FLUSH.
REQ-023 RUN -> FLUSH when any cap_locked bit falls, when error count reaches MAX_ERRORS, or on overrun (REQ-026).
REQ-024 Assembly (RUN only): on cap_ready[i], latch cap_q[i] into word bit i and set pending[i]; when all pending bits set (including same-cycle strobes), data SHALL update and valid SHALL pulse one clk later, pending cleared that cycle.
REQ-025 Strobes arriving in the same cycle as word completion for an already-counted channel are an overrun, not the next word.
REQ-026 Overrun: cap_ready[i] with pending[i] already set SHALL discard the partial word, emit no valid, and resync.
REQ-027 cap_ack SHALL be a registered copy of cap_invalid in RUN, 0 in all other states.
REQ-028 Error count (width clog2(MAX_ERRORS+1)) SHALL increment by 1 per ce-cycle in which at least one cap_invalid bit rises, saturating at MAX_ERRORS.
REQ-029 resyncs SHALL saturate at 255; IDLE->FLUSH does not count.
REQ-030 data holds its last value between valid strobes.

Reset
REQ-031 On rst: state=IDLE, cap_rst=1, cap_ack=0, valid=0, data=0, resyncs=0, pending=0, timers and error count 0.
REQ-032 rst mid-word or mid-FLUSH SHALL discard all partial state with no valid pulse.

Configuration
REQ-033 Macro CAPTURE_CTRL_SKEW_EN: when defined, a 4-bit per-word skew counter (ce-cycles from first to last strobe of a word) SHALL trigger resync if it exceeds 2; without it, skew is unchecked and skew logic absent.

Structure
REQ-034 Package capture_pkg SHALL hold the state enum, state encodings and default parameter constants.
REQ-035 Sub-module capture_assembler SHALL implement pending/word latching and overrun detection (REQ-024..026).

Verification
REQ-036 NUM_CH=4, all locked after 10 ce-cycles -> FLUSH 4 cycles, RUN, resyncs=0.
REQ-037 Ready strobes ch0..3 at staggered cycles with q=1,0,1,1 -> one valid pulse, data=4'b1101.
REQ-038 cap_ready[2] twice before word completes -> no valid, FLUSH entered, resyncs=1.
REQ-039 Three separate invalid rises on ch1 in RUN -> cap_ack[1] follows each, third triggers FLUSH.
REQ-040 Channel 3 never locks, LOCK_TIMEOUT=16 -> FLUSH after 16 ce-cycles, repeating, resyncs increments each time.
REQ-041 enable dropped mid-word in RUN -> IDLE next clk, cap_rst=1, no valid pulse.
